// File: rtl/find_stars_pkg.sv
// Shared constants and the box-drawing state encoding for the star-finder datapath.
package find_stars_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COL_W    = 3;
    localparam int XW       = 8;
    localparam int YW       = 7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAW     = 2'd1,
        DONE     = 2'd2,
        WAIT_REL = 2'd3
    } draw_state_e;

endpackage

// File: rtl/box_offset_counter.sv
// Signed row-major raster over a (2*HALF+1)^2 window: dx runs fastest, dy steps on dx wrap.
module box_offset_counter #(
    parameter int HALF = 2,
    parameter int DW   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n_i,
    input  logic                 clr_i,
    input  logic                 en_i,
    output logic signed [DW-1:0] dx_o,
    output logic signed [DW-1:0] dy_o,
    output logic                 last_o
);

    localparam logic signed [DW-1:0] HI = DW'(HALF);
    localparam logic signed [DW-1:0] LO = -HI;

    logic signed [DW-1:0] dx_q, dx_d;
    logic signed [DW-1:0] dy_q, dy_d;

    always_comb begin
        dx_d = dx_q;
        dy_d = dy_q;
        if (clr_i) begin
            dx_d = LO;
            dy_d = LO;
        end else if (en_i) begin
            if (dx_q == HI) begin
                dx_d = LO;
                dy_d = (dy_q == HI) ? LO : dy_q + DW'(1);
            end else begin
                dx_d = dx_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dx_q <= '0;
            dy_q <= '0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

    assign dx_o   = dx_q;
    assign dy_o   = dy_q;
    assign last_o = (dx_q == HI) && (dy_q == HI);

endmodule

// File: rtl/star_box_drawer.sv
// Plots a clipped square outline (or a filled square when FILL_BOX_EN is defined)
// around a star centre into the VGA frame buffer, one window position per cycle.
module star_box_drawer #(
    parameter int XW    = find_stars_pkg::XW,
    parameter int YW    = find_stars_pkg::YW,
    parameter int COL_W = find_stars_pkg::COL_W,
    parameter int HALF  = 2,
    parameter int X_MAX = find_stars_pkg::SCREEN_W - 1,
    parameter int Y_MAX = find_stars_pkg::SCREEN_H - 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             go_draw,
    input  logic [XW-1:0]    x_in,
    input  logic [YW-1:0]    y_in,
    input  logic [COL_W-1:0] colour_in,
    output logic             plot,
    output logic [XW-1:0]    x_out,
    output logic [YW-1:0]    y_out,
    output logic [COL_W-1:0] colour_out,
    output logic             busy,
    output logic             done_draw
);

    import find_stars_pkg::*;

    // One extra bit over the magnitude so -HALF..+HALF fits in two's complement.
    localparam int DW = $clog2(HALF + 1) + 1;

    draw_state_e state_q, state_d;

    logic [XW-1:0]    cx_q, cx_d;
    logic [YW-1:0]    cy_q, cy_d;
    logic [COL_W-1:0] col_q, col_d;

    logic                 cnt_clr, cnt_en, cnt_last, load;
    logic signed [DW-1:0] dx, dy;

    box_offset_counter #(
        .HALF (HALF),
        .DW   (DW)
    ) u_offset (
        .clk     (clk),
        .rst_n_i (resetn),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .dx_o    (dx),
        .dy_o    (dy),
        .last_o  (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (go_draw) begin
                    state_d = DRAW;
                    cnt_clr = 1'b1;
                    load    = 1'b1;
                end
            end
            DRAW: begin
                cnt_en = 1'b1;
                if (cnt_last) state_d = DONE;
            end
            DONE:     state_d = go_draw ? WAIT_REL : IDLE;
            WAIT_REL: if (!go_draw) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        cx_d  = load ? x_in      : cx_q;
        cy_d  = load ? y_in      : cy_q;
        col_d = load ? colour_in : col_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            col_q   <= col_d;
        end
    end

    // Two guard bits: the sign bit catches left/top clipping, the extra magnitude
    // bit keeps cx+HALF from wrapping back onto the screen.
    logic signed [XW+1:0] px;
    logic signed [YW+1:0] py;
    logic                 on_x, on_y, on_perim, in_draw;

    assign px = $signed({2'b00, cx_q}) + $signed({{(XW + 2 - DW){dx[DW-1]}}, dx});
    assign py = $signed({2'b00, cy_q}) + $signed({{(YW + 2 - DW){dy[DW-1]}}, dy});

    assign on_x = !px[XW+1] && (px[XW:0] <= (XW + 1)'(X_MAX));
    assign on_y = !py[YW+1] && (py[YW:0] <= (YW + 1)'(Y_MAX));

`ifdef FILL_BOX_EN
    assign on_perim = 1'b1;
`else
    assign on_perim = (dx == DW'(HALF)) || (dx == -DW'(HALF)) ||
                      (dy == DW'(HALF)) || (dy == -DW'(HALF));
`endif

    assign in_draw    = (state_q == DRAW);
    assign plot       = in_draw && on_perim && on_x && on_y;
    assign x_out      = plot ? px[XW-1:0] : '0;
    assign y_out      = plot ? py[YW-1:0] : '0;
    assign colour_out = plot ? col_q : '0;
    assign busy       = in_draw || (state_q == DONE);
    assign done_draw  = (state_q == DONE);

endmodule
